// File: rtl/hamming_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time, low nibble then high nibble,
// through a shared external Hamming(7,4) encoder onto a valid/ready codeword stream.
module hamming_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [3:0]           enc_data,
  input  logic [6:0]           enc_code,
  output logic                 cw_valid,
  output logic [6:0]           cw_data,
  output logic [SRC_W-1:0]     cw_src,
  output logic                 cw_hi,
  input  logic                 cw_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     byte_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [7:0]       buffer;
  logic [SRC_W-1:0] last;
  logic [SRC_W-1:0] grant;
  logic             grant_found;
  logic             can_accept;
  logic             accept;
  logic [7:0]       grant_byte;

  // Search starts one past the last winner and wraps, so the previous winner is checked last.
  always_comb begin
    int unsigned idx;
    logic [SRC_W-1:0] idx_s;
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    idx_s       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_s = SRC_W'(idx);
      if (!grant_found && req_valid[idx_s]) begin
        grant_found = 1'b1;
        grant       = idx_s;
      end
    end
  end

  assign grant_byte = req_data[8*grant +: 8];
  assign can_accept = (state == IDLE) || ((state == HIGH) && cw_ready);
  assign accept     = grant_found && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (accept) state_d = LOW;
      LOW:     if (cw_ready) state_d = HIGH;
      HIGH:    if (cw_ready) state_d = accept ? LOW : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buffer     <= '0;
      last       <= SRC_W'(NUM_REQ - 1);
      cw_src     <= '0;
      enc_data   <= '0;
      byte_count <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        buffer   <= grant_byte;
        cw_src   <= grant;
        last     <= grant;
        enc_data <= grant_byte[3:0];
      end else if ((state == LOW) && cw_ready) begin
        enc_data <= buffer[7:4];
      end
      if ((state == HIGH) && cw_ready) byte_count <= byte_count + CNT_W'(1);
    end
  end

  assign cw_valid = (state != IDLE);
  assign cw_hi    = (state == HIGH);
  assign busy     = (state != IDLE);
  assign cw_data  = enc_code;

endmodule

// File: tb/tb_hamming_tx_arbiter.sv
// Directed bench for hamming_tx_arbiter with the shared Hamming(7,4) encoder modelled locally.
module tb_hamming_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  enc_data;
  logic [6:0]  enc_code;
  logic        cw_valid;
  logic [6:0]  cw_data;
  logic [1:0]  cw_src;
  logic        cw_hi;
  logic        cw_ready;
  logic        busy;
  logic [3:0]  byte_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Codeword layout {d3,d2,d1,d0,p2,p1,p0}
  assign enc_code = {enc_data,
                     enc_data[1] ^ enc_data[2] ^ enc_data[3],
                     enc_data[0] ^ enc_data[2] ^ enc_data[3],
                     enc_data[0] ^ enc_data[1] ^ enc_data[3]};

  hamming_tx_arbiter #(.NUM_REQ(4), .SRC_W(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .enc_data(enc_data), .enc_code(enc_code),
    .cw_valid(cw_valid), .cw_data(cw_data), .cw_src(cw_src), .cw_hi(cw_hi),
    .cw_ready(cw_ready), .busy(busy), .byte_count(byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-computed codewords for bytes 00, FF, 12, 34 on requesters 0..3
  logic [6:0] lo_code [4] = '{7'h00, 7'h7F, 7'h15, 7'h26};
  logic [6:0] hi_code [4] = '{7'h00, 7'h7F, 7'h0B, 7'h1E};

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; cw_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    tick();
    chk("rst_cw_valid", 32'(cw_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(byte_count), 0);
    chk("rst_cw_hi", 32'(cw_hi), 0);
    chk("rst_cw_src", 32'(cw_src), 0);
    chk("rst_enc_data", 32'(enc_data), 0);

    // Single byte 0xA5 from requester 0
    rst = 1'b0; req_valid = 4'b0001; req_data = 32'h000000A5; cw_ready = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_lo_valid", 32'(cw_valid), 1);
    chk("t1_lo_data", 32'(cw_data), 32'h2D);
    chk("t1_lo_hi", 32'(cw_hi), 0);
    chk("t1_lo_src", 32'(cw_src), 0);
    chk("t1_lo_count", 32'(byte_count), 0);
    tick();
    chk("t1_hi_data", 32'(cw_data), 32'h52);
    chk("t1_hi_hi", 32'(cw_hi), 1);
    tick();
    chk("t1_idle_valid", 32'(cw_valid), 0);
    chk("t1_count", 32'(byte_count), 1);

    // Round robin with all four requesters valid
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b1111; req_data = 32'h3412FF00; cw_ready = 1'b1;
    #1;
    chk("rr_first_ready", 32'(req_ready), 32'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("rr_lo_src", 32'(cw_src), 32'(k % 4));
      chk("rr_lo_hi", 32'(cw_hi), 0);
      chk("rr_lo_data", 32'(cw_data), 32'(lo_code[k % 4]));
      chk("rr_lo_ready", 32'(req_ready), 0);
      tick();
      chk("rr_hi_hi", 32'(cw_hi), 1);
      chk("rr_hi_data", 32'(cw_data), 32'(hi_code[k % 4]));
      chk("rr_hi_ready", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
      tick();
    end
    chk("rr_sixth_src", 32'(cw_src), 1);
    req_valid = '0;
    tick();
    tick();
    chk("rr_drain_valid", 32'(cw_valid), 0);
    chk("rr_count", 32'(byte_count), 6);

    // Stall in LOW then in HIGH
    req_data = 32'h3412FFA5; req_valid = 4'b0001; cw_ready = 1'b0;
    #1;
    chk("st_idle_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0100;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("st_lo_valid", 32'(cw_valid), 1);
      chk("st_lo_data", 32'(cw_data), 32'h2D);
      chk("st_lo_src", 32'(cw_src), 0);
      chk("st_lo_hi", 32'(cw_hi), 0);
      chk("st_lo_ready", 32'(req_ready), 0);
      tick();
    end
    cw_ready = 1'b1;
    tick();
    cw_ready = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("st_hi_valid", 32'(cw_valid), 1);
      chk("st_hi_data", 32'(cw_data), 32'h52);
      chk("st_hi_src", 32'(cw_src), 0);
      chk("st_hi_hi", 32'(cw_hi), 1);
      chk("st_hi_ready", 32'(req_ready), 0);
      chk("st_hi_count", 32'(byte_count), 6);
      tick();
    end
    req_valid = '0; cw_ready = 1'b1;
    tick();
    chk("st_count", 32'(byte_count), 7);
    chk("st_idle_valid", 32'(cw_valid), 0);

    // Accept overlapping the HIGH handshake
    req_valid = 4'b0010;
    #1;
    chk("ov_req1_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0100;
    #1;
    chk("ov_lo_src", 32'(cw_src), 1);
    chk("ov_lo_data", 32'(cw_data), 32'h7F);
    chk("ov_lo_ready", 32'(req_ready), 0);
    tick();
    chk("ov_hi_hi", 32'(cw_hi), 1);
    chk("ov_hi_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    chk("ov_next_valid", 32'(cw_valid), 1);
    chk("ov_next_hi", 32'(cw_hi), 0);
    chk("ov_next_src", 32'(cw_src), 2);
    chk("ov_next_data", 32'(cw_data), 32'h15);
    chk("ov_count", 32'(byte_count), 8);
    tick();

    // Reset while stalled in HIGH
    cw_ready = 1'b0; rst = 1'b1; req_valid = 4'b1001;
    #1;
    chk("mr_in_high", 32'(cw_hi), 1);
    chk("mr_ready_rst", 32'(req_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(cw_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_count", 32'(byte_count), 0);
    chk("mr_grant0", 32'(req_ready), 32'h1);
    tick();
    chk("mr_lo_src", 32'(cw_src), 0);
    chk("mr_lo_data", 32'(cw_data), 32'h2D);
    req_valid = '0; cw_ready = 1'b1;
    tick();
    tick();

    // Counter wrap: 17 back-to-back bytes with a 4-bit counter
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0001; cw_ready = 1'b1;
    for (int k = 0; k < 32; k++) tick();
    chk("wr_pre_hi", 32'(cw_hi), 1);
    chk("wr_pre_count", 32'(byte_count), 15);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk("wr_count", 32'(byte_count), 1);
    chk("wr_idle", 32'(cw_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
